ft2232h_rx_ctrl: RTL and testbench
==================================

Name: ft2232h_rx_ctrl

Overview:
FPGA-side read controller for the FT2232H synchronous 245 FIFO receive path (USB host -> FPGA).
- Watches RXF#, sequences OE# then RD# and captures bytes.
- Buffers captured bytes in an internal first-word-fall-through FIFO.
- Presents them to the downstream command/data logic as a valid/ready byte stream.
- Sits directly downstream of the FT2232H receive interface, clocked by the 60 MHz FT2232H CLKOUT.

Parameters:
ADDR_W, 4, internal buffer address width; depth DEPTH = 2**ADDR_W (16 entries).
MIN_FREE, 2, free-entry threshold; a burst may start or continue only while free >= MIN_FREE (covers the one-cycle RD# deassert latency).

Ports:
clk_i  input  1  FT2232H CLKOUT; all logic on posedge.
rstn_i  input  1  reset; synchronous, active-low.
en_i  input  1  enable; 0 = start no new burst, and end any current burst.
ft_data_i  input  8  FT2232H data bus (read direction).
ft_rxf_n_i  input  1  RXF#, low = FT2232H holds unread data.
ft_oe_n_o  output  1  OE#, low = FT2232H drives the bus.
ft_rd_n_o  output  1  RD#, low = read strobe.
m_data_o  output  8  head byte of the buffer.
m_valid_o  output  1  buffer not empty.
m_ready_i  input  1  downstream accepts m_data_o.
busy_o  output  1  state != IDLE.

Behaviour:
- Reset: clock and reset are as fixed above (one clock; reset is synchronous and active-low).
  - Outputs: ft_oe_n_o=1, ft_rd_n_o=1, m_valid_o=0, m_data_o=0, busy_o=0.
  - Internal: state=IDLE, buffer empty, pointers=0.
  - Reset asserted mid-burst releases OE#/RD# at that same edge; bytes already buffered are discarded.
- ft_oe_n_o and ft_rd_n_o are registered outputs; there is no combinational path from ft_rxf_n_i to them.
- free = DEPTH - level, evaluated before the current edge's push/pop.
- FSM:
  - IDLE (oe=1, rd=1): go to OE_ON when en_i && !ft_rxf_n_i && free>=MIN_FREE.
  - OE_ON (oe=0, rd=1), exactly 1 cycle: go to READ if !ft_rxf_n_i, else go to TURN.
  - READ (oe=0, rd=0): stay while !ft_rxf_n_i && en_i && free>=MIN_FREE. Otherwise go to TURN.
  - TURN (oe=1, rd=1), exactly 1 cycle, bus turnaround: go to IDLE.
- Capture: at any posedge where ft_rd_n_o==0 and ft_rxf_n_i==0, push ft_data_i.
  - The first byte is captured on the first edge after RD# goes low.
  - No capture in OE_ON, TURN or IDLE.
- Throughput: 1 byte/clk in READ. Per-burst overhead is 2 cycles (OE_ON + TURN) plus 1 IDLE cycle.
- Buffer:
  - FWFT: m_data_o equals the head entry whenever m_valid_o=1, and holds its value while m_ready_i=0.
  - Pop on m_valid_o && m_ready_i.
  - Push and pop on the same edge: both are performed and level is unchanged.
  - Pointers wrap modulo DEPTH.
  - The MIN_FREE throttle guarantees a push never occurs while full. Overflow must be unreachable; assert this in simulation.
- RXF# rising mid-burst: no capture on that edge; go to TURN next.
- Buffer reaching free<MIN_FREE mid-burst: at most one more byte is captured (the edge on which RD# deasserts), then TURN.
- en_i falling mid-burst: same as above (end burst via TURN). Bytes already buffered still drain.

Optional Feature:
FT_RX_STATS_EN
- Defined:
  - Adds output rx_count_o[15:0]: count of captured bytes, reset to 0, +1 per push, wraps 0xFFFF -> 0x0000.
  - Adds output rx_stall_o: 1-cycle pulse when READ exits because of free<MIN_FREE.
- Undefined: neither port nor logic exists. Core behaviour is identical in both builds.

Test Plan:
1. Reset with rstn_i=0 for 3 clks, then ft_rxf_n_i=0, en_i=1, m_ready_i=1 -> OE# low 1 cycle, then RD# low; bytes 0x01..0x08 appear on m_data_o in order, one per clk.
2. RXF# low for exactly 5 bytes (0xA0..0xA4) then high -> exactly 5 pushes; RD# high the cycle after RXF# is sampled high; TURN 1 cycle; no 6th byte.
3. m_ready_i=0, continuous data -> burst stops with level DEPTH-1 or DEPTH and no overflow. Then m_ready_i=1 -> all 16 bytes drain in order, and a new burst resumes once free>=2.
4. rstn_i=0 asserted mid-READ after 3 bytes -> OE#/RD# high at that edge, m_valid_o=0; after release a fresh burst starts from IDLE.
5. en_i deasserted mid-burst -> TURN then IDLE; buffered bytes still delivered; no new OE# while en_i=0 even though ft_rxf_n_i=0.
6. FT_RX_STATS_EN defined, 70000 bytes streamed -> rx_count_o=0x1170 (70000 mod 65536); rx_stall_o pulses once per forced stop in scenario 3.

Source files
------------

// File: rtl/ft2232h_rx_ctrl.sv
// FT2232H sync-245 receive controller: sequences OE#/RD# on RXF#, buffers bytes in a 16-deep FWFT FIFO, streams them out valid/ready.
// Latency: OE# low 1 clk after RXF# seen low, first byte captured 2 clks later, visible on m_data_o the cycle after capture.
// Backpressure: m_ready_i low fills the buffer; bursts stop once free < MIN_FREE. Optional build macro FT_RX_STATS_EN adds rx_count_o/rx_stall_o.
module ft2232h_rx_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int MIN_FREE = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic [7:0] ft_data_i,
    input  logic       ft_rxf_n_i,
    output logic       ft_oe_n_o,
    output logic       ft_rd_n_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       busy_o
`ifdef FT_RX_STATS_EN
    ,
    output logic [15:0] rx_count_o,
    output logic        rx_stall_o
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   MIN_L   = MIN_FREE[ADDR_W:0];
    localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OE_ON = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   free;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        mem [DEPTH];
    logic              room;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // free space is judged on the level before this edge's push/pop
    assign free  = DEPTH_L - level;
    assign room  = (free >= MIN_L);
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // a byte is taken on every edge where the strobe is low and the chip still has data
    assign push      = !ft_rd_n_o && !ft_rxf_n_i;
    assign pop       = m_valid_o && m_ready_i;
    assign m_valid_o = !empty;
    assign m_data_o  = empty ? 8'h00 : mem[rd_ptr];
    assign busy_o    = (state != IDLE);

    // burst sequencing: IDLE -> OE_ON -> READ ... -> TURN -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_i && !ft_rxf_n_i && room) state_nxt = OE_ON;
            OE_ON:   state_nxt = ft_rxf_n_i ? TURN : READ;
            READ:    if (!(!ft_rxf_n_i && en_i && room)) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state plus OE#/RD# registered from the next state so the pins are glitch-free flops
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            ft_oe_n_o <= 1'b1;
            ft_rd_n_o <= 1'b1;
        end else begin
            state     <= state_nxt;
            ft_oe_n_o <= !((state_nxt == OE_ON) || (state_nxt == READ));
            ft_rd_n_o <= !(state_nxt == READ);
        end
    end

    // buffer pointers and fill level; reset discards anything still buffered
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            assert (!(push && full));
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // buffer storage, written only outside reset
    always_ff @(posedge clk_i) begin
        if (rstn_i && push) mem[wr_ptr] <= ft_data_i;
    end

`ifdef FT_RX_STATS_EN
    // captured-byte counter (wraps) and a pulse whenever READ is cut short by a full buffer
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_count_o <= 16'h0000;
            rx_stall_o <= 1'b0;
        end else begin
            if (push) rx_count_o <= rx_count_o + 16'h0001;
            rx_stall_o <= (state == READ) && !room;
        end
    end
`endif

endmodule

// File: tb/tb_ft2232h_rx_ctrl.sv
// Directed bench for ft2232h_rx_ctrl: emulates the FT2232H byte source and a downstream sink.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge or 1 unit after posedge.
// Sink checks every popped byte against a hand-sequenced expected byte.
module tb_ft2232h_rx_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [7:0] ft_data;
    logic       ft_rxf_n;
    logic       ft_oe_n;
    logic       ft_rd_n;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
`ifdef FT_RX_STATS_EN
    logic [15:0] rx_count;
    logic        rx_stall;
`endif

    int         n_cmp;
    int         n_err;
    int         pushes;
    int         pops;
    int         stalls;
    int         p0;
    int         src_left;
    logic [7:0] src_byte;
    logic [7:0] exp_byte;
    logic       oe_seen_low;

    ft2232h_rx_ctrl #(.ADDR_W(4), .MIN_FREE(2)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .en_i       (en),
        .ft_data_i  (ft_data),
        .ft_rxf_n_i (ft_rxf_n),
        .ft_oe_n_o  (ft_oe_n),
        .ft_rd_n_o  (ft_rd_n),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .busy_o     (busy)
`ifdef FT_RX_STATS_EN
        ,
        .rx_count_o (rx_count),
        .rx_stall_o (rx_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input logic [7:0] b, input int n);
        src_byte = b;
        src_left = n;
        ft_data  = b;
        ft_rxf_n = (n == 0);
    endtask

    // one clock: sample at negedge, advance the emulated chip after the edge
    task automatic tick();
        logic wp;
        logic wpop;
        @(negedge clk);
        wp   = rstn && !ft_rd_n && !ft_rxf_n;
        wpop = rstn && m_valid && m_ready;
        if (!ft_oe_n) oe_seen_low = 1'b1;
`ifdef FT_RX_STATS_EN
        if (rx_stall) stalls++;
`endif
        if (wpop) begin
            chk("pop_data", m_data, exp_byte);
            exp_byte = exp_byte + 8'd1;
            pops++;
        end
        @(posedge clk);
        #1;
        if (wp) begin
            src_byte = src_byte + 8'd1;
            src_left--;
            pushes++;
        end
        ft_data  = src_byte;
        ft_rxf_n = (src_left == 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; pushes = 0; pops = 0; stalls = 0;
        oe_seen_low = 1'b0;
        rstn = 1'b0; en = 1'b0; m_ready = 1'b0;
        exp_byte = 8'h00;
        set_src(8'h00, 0);

        // 1: reset state, then an 8-byte burst
        repeat (3) tick();
        chk("rst_oe", ft_oe_n, 1);
        chk("rst_rd", ft_rd_n, 1);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1; en = 1'b1; m_ready = 1'b1;
        set_src(8'h01, 8); exp_byte = 8'h01; p0 = pushes;
        tick();
        chk("s1_oe_on", ft_oe_n, 0);
        chk("s1_rd_hi", ft_rd_n, 1);
        chk("s1_busy", busy, 1);
        tick();
        chk("s1_read_oe", ft_oe_n, 0);
        chk("s1_read_rd", ft_rd_n, 0);
        repeat (8) tick();
        chk("s1_pushes", pushes - p0, 8);
        chk("s1_rd_still", ft_rd_n, 0);
        tick();
        chk("s1_turn_rd", ft_rd_n, 1);
        chk("s1_turn_oe", ft_oe_n, 1);
        chk("s1_turn_busy", busy, 1);
        tick();
        chk("s1_idle_busy", busy, 0);
        repeat (3) tick();
        chk("s1_all_out", exp_byte, 8'h09);
        chk("s1_empty", m_valid, 0);

        // 2: exactly five bytes then RXF# rises
        set_src(8'hA0, 5); exp_byte = 8'hA0; p0 = pushes;
        repeat (7) tick();
        chk("s2_pushes", pushes - p0, 5);
        chk("s2_rd_low", ft_rd_n, 0);
        tick();
        chk("s2_turn_rd", ft_rd_n, 1);
        chk("s2_turn_oe", ft_oe_n, 1);
        chk("s2_turn_busy", busy, 1);
        tick();
        chk("s2_idle", busy, 0);
        repeat (4) tick();
        chk("s2_no_6th", pushes - p0, 5);
        chk("s2_all_out", exp_byte, 8'hA5);
        chk("s2_empty", m_valid, 0);

        // 3: sink stalled, buffer fills, then drains and the burst resumes
        m_ready = 1'b0;
        set_src(8'h10, 1000); exp_byte = 8'h10; p0 = pushes;
        repeat (25) tick();
        chk("s3_fill", pushes - p0, 16);
        chk("s3_valid", m_valid, 1);
        chk("s3_head", m_data, 8'h10);
        chk("s3_oe", ft_oe_n, 1);
        chk("s3_rd", ft_rd_n, 1);
        chk("s3_idle", busy, 0);
`ifdef FT_RX_STATS_EN
        chk("s3_stall_cnt", stalls, 1);
`endif
        m_ready = 1'b1;
        tick();
        chk("s3_wait1", ft_oe_n, 1);
        tick();
        chk("s3_wait2", ft_oe_n, 1);
        tick();
        chk("s3_resume", ft_oe_n, 0);
        repeat (30) tick();
        set_src(src_byte, 0);
        repeat (25) tick();
        chk("s3_pushes", pushes - p0, 45);
        chk("s3_all_out", exp_byte, 8'h3D);
        chk("s3_empty", m_valid, 0);
        chk("s3_idle2", busy, 0);
`ifdef FT_RX_STATS_EN
        chk("s3_stall_once", stalls, 1);
`endif

        // 4: reset in the middle of READ
        set_src(8'h30, 10); exp_byte = 8'h30; p0 = pushes;
        repeat (5) tick();
        chk("s4_pushes", pushes - p0, 3);
        chk("s4_rd_low", ft_rd_n, 0);
        rstn = 1'b0;
        tick();
        chk("s4_rst_oe", ft_oe_n, 1);
        chk("s4_rst_rd", ft_rd_n, 1);
        chk("s4_rst_valid", m_valid, 0);
        chk("s4_rst_data", m_data, 0);
        chk("s4_rst_busy", busy, 0);
        exp_byte = 8'h33;
        rstn = 1'b1;
        tick();
        chk("s4_oe_on", ft_oe_n, 0);
        chk("s4_rd_hi", ft_rd_n, 1);
        repeat (15) tick();
        chk("s4_all_out", exp_byte, 8'h3A);
        chk("s4_pushes2", pushes - p0, 10);
        chk("s4_empty", m_valid, 0);
`ifdef FT_RX_STATS_EN
        chk("s4_count", rx_count, 16'd7);
`endif

        // 5: enable dropped mid-burst
        m_ready = 1'b0;
        set_src(8'h50, 20); exp_byte = 8'h50; p0 = pushes;
        repeat (5) tick();
        chk("s5_pushes", pushes - p0, 3);
        en = 1'b0;
        tick();
        chk("s5_turn_rd", ft_rd_n, 1);
        chk("s5_turn_oe", ft_oe_n, 1);
        chk("s5_turn_busy", busy, 1);
        chk("s5_last_byte", pushes - p0, 4);
        tick();
        chk("s5_idle", busy, 0);
        oe_seen_low = 1'b0;
        repeat (6) tick();
        chk("s5_no_oe", oe_seen_low, 0);
        chk("s5_valid", m_valid, 1);
        chk("s5_head", m_data, 8'h50);
        m_ready = 1'b1;
        repeat (8) tick();
        chk("s5_drained", exp_byte, 8'h54);
        chk("s5_empty", m_valid, 0);
        set_src(8'h00, 0);
        en = 1'b1;
        tick();

`ifdef FT_RX_STATS_EN
        // 6: long stream to wrap the byte counter
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        stalls = 0;
        set_src(8'h00, 70000); exp_byte = 8'h00; p0 = pushes;
        repeat (70010) tick();
        chk("s6_count", rx_count, 16'h1170);
        chk("s6_all_out", exp_byte, 8'h70);
        chk("s6_no_stall", stalls, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
